rfa_serial_adder_ctrl: RTL
==========================

# rfa_serial_adder_ctrl

Bit-serial N-bit adder controller built around one instance of the team's reversible full-adder cell (sum, cout, 4-bit out_vec). The block:

- accepts two operands and a carry-in through a start/ready handshake;
- feeds the cell one bit pair per clock, LSB first, with the carry recirculated through a register;
- assembles the sum and presents it with a one-cycle done pulse.

It also checks the cell's garbage outputs every cycle as a built-in self-test. It sits between operand-producing logic and the single shared reversible adder cell.

## Interface

Parameters:

- WIDTH, 8, operand and sum width in bits; legal values are ≥ 2.

Ports:

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only while ready=1.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- ready  output  1  high in IDLE; start is accepted only when ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; sum, cout and err are valid in this cycle.
- sum  output  WIDTH  result register; holds its value until the next completion.
- cout  output  1  final carry-out register; holds its value until the next completion.
- err  output  1  sticky self-test failure flag.

## Operation

State machine: IDLE, RUN, DONE.

- **IDLE** (ready=1).
  - start=1: load a→sha, b→shb, cin→carry; clear cnt and err; go to RUN.
  - start=0: stay in IDLE.
- **RUN** (busy=1). Each cycle:
  - Drive the cell with a=sha[0], b=shb[0], cin=carry.
  - carry ← cell cout.
  - Shift the cell sum into shs from the MSB end: shs ← {cell_sum, shs[WIDTH-1:1]}.
  - Shift sha and shb right by one.
  - cnt ← cnt+1.
  - When cnt==WIDTH-1, go to DONE. On that same edge, load sum ← {cell_sum, shs[WIDTH-1:1]} and cout ← cell cout.
- **DONE**: done=1 for exactly one cycle, then unconditionally go to IDLE. start is ignored in DONE.

Other rules:

- start while busy or in DONE is ignored and has no side effects. Operand inputs are don't-care outside the accepting cycle.
- cnt is ceil(log2(WIDTH)) bits wide; it never wraps because the FSM exits RUN at WIDTH-1.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Self-test, evaluated every RUN cycle from the cell's out_vec = {garb0, garb1, sum, cout}:
  - expected garb0 = current a bit;
  - expected garb1 = a bit XOR b bit;
  - expected {cout,sum} = the arithmetic full-adder result of the current a, b and carry bits.
  - Any mismatch sets err. err stays high until rst or the next accepted start.
- Reset (from any state, including mid-RUN) forces:
  - state=IDLE, ready=1, busy=0, done=0;
  - sum=0, cout=0, err=0, and all shift registers, cnt and carry cleared.
  - Partial results are discarded.

## Timing

- Cycle 0: the edge at which start=1 and ready=1 are sampled.
- RUN occupies cycles 1..WIDTH; busy=1 throughout.
- done=1 in cycle WIDTH+1, with sum and cout already valid in that cycle.
- ready returns to 1 in cycle WIDTH+2.
- Start-to-done latency is WIDTH+1 cycles; issue interval is WIDTH+2 cycles.
- All outputs are registered or decoded directly from state; there is no combinational path from start, a, b or cin to any output.
- The cell is purely combinational; the only carry feedback path is cell cout → carry register.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, cin=0 → done exactly 9 cycles after the start edge; sum=0x96, cout=0, err=0; ready=1 the next cycle.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Results hold between operations.
- Pulse start with a=0x11, b=0x22 in cycle 3 of an active a=0x01, b=0x01 operation → the second start is ignored; result sum=0x02, cout=0; only one done pulse.
- Assert rst in cycle 4 of RUN → the next cycle shows ready=1, busy=0, done=0, sum=0, cout=0, err=0. A subsequent start with a=0x80, b=0x80 gives sum=0x00, cout=1.
- Force the cell's garb1 inverted for one RUN cycle (bench force) → err=1 at done and remains 1 through IDLE. The next accepted start clears err to 0.
- Random sweep, 1000 operand triples with back-to-back starts issued as soon as ready=1 → {cout,sum} equals a+b+cin on every done, err stays 0, and done pulses are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/rfa_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rfa_serial_adder_ctrl (with leaf cell rfa_cell)
// Purpose  : Bit-serial WIDTH-bit adder controller wrapped around a single
//            reversible full-adder cell. Operands are taken through a
//            start/ready handshake, fed to the cell LSB first with the carry
//            recirculated through a register, and the assembled sum is
//            presented with a one-cycle done pulse. The cell's garbage
//            outputs are cross-checked every RUN cycle as a built-in
//            self-test (sticky err flag).
// Ports    : clk   - rising-edge clock
//            rst   - synchronous active-high reset
//            start - request, sampled only while ready=1
//            a, b  - operands, captured on the accepted start
//            cin   - carry-in, captured on the accepted start
//            ready - high in IDLE
//            busy  - high in RUN
//            done  - one-cycle completion pulse
//            sum   - result register, held until the next completion
//            cout  - final carry register, held until the next completion
//            err   - sticky self-test failure flag
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// rfa_cell: purely combinational reversible full adder.
// out_vec_o = {garb0, garb1, sum, cout} where garb0 = a and garb1 = a ^ b.
// ----------------------------------------------------------------------------
module rfa_cell (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   output logic       sum_o,
   output logic       cout_o,
   output logic [3:0] out_vec_o
);
   logic w_p;

   assign w_p       = a_i ^ b_i;
   assign sum_o     = w_p ^ cin_i;
   assign cout_o    = (a_i & b_i) | (cin_i & w_p);
   assign out_vec_o = {a_i, w_p, sum_o, cout_o};
endmodule

module rfa_serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             err
);
   localparam int                 c_CNT_W    = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   sha_q;
   logic [WIDTH-1:0]   shb_q;
   logic [WIDTH-1:0]   shs_q;
   logic [WIDTH-1:0]   sum_q;
   logic [c_CNT_W-1:0] cnt_q;
   logic               carry_q;
   logic               cout_q;
   logic               err_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;

   logic               w_cell_sum;
   logic               w_cell_cout;
   logic [3:0]         w_cell_vec;
   logic [WIDTH-1:0]   w_shs_d;
   logic [1:0]         w_fa_ref;
   logic [3:0]         w_vec_ref;
   logic               w_st_fail;

   rfa_cell u_cell (
      .a_i       (sha_q[0]),
      .b_i       (shb_q[0]),
      .cin_i     (carry_q),
      .sum_o     (w_cell_sum),
      .cout_o    (w_cell_cout),
      .out_vec_o (w_cell_vec)
   );

   // Sum bits enter at the MSB end so that after WIDTH shifts bit 0 sits at LSB.
   assign w_shs_d = {w_cell_sum, shs_q[WIDTH-1:1]};

   // Self-test reference: garbage lines from the operand bits, and the
   // sum/carry pair from plain arithmetic rather than the cell's gate form.
   assign w_fa_ref  = {1'b0, sha_q[0]} + {1'b0, shb_q[0]} + {1'b0, carry_q};
   assign w_vec_ref = {sha_q[0], sha_q[0] ^ shb_q[0], w_fa_ref[0], w_fa_ref[1]};
   assign w_st_fail = (w_cell_vec != w_vec_ref);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         shs_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sha_q   <= a;
                  shb_q   <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  state_q <= S_RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               carry_q <= w_cell_cout;
               shs_q   <= w_shs_d;
               sha_q   <= sha_q >> 1;
               shb_q   <= shb_q >> 1;
               if (w_st_fail) begin
                  err_q <= 1'b1;
               end
               if (cnt_q == c_CNT_LAST) begin
                  // Final bit: publish the result straight from the shift path.
                  sum_q   <= w_shs_d;
                  cout_q  <= w_cell_cout;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + c_CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign err   = err_q;
endmodule

`default_nettype wire
